// File: rtl/arc4_prga.sv
// ARC4 keystream generation and decryption stage.
// Reads length-prefixed ciphertext, writes length-prefixed plaintext.
module arc4_prga #(
    parameter bit CHECK_ASCII  = 1'b1,
    parameter bit ABORT_ON_BAD = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    output logic       rdy,
    output logic       pt_bad,
    output logic [7:0] s_addr,
    input  logic [7:0] s_rddata,
    output logic [7:0] s_wrdata,
    output logic       s_wren,
    output logic [7:0] ct_addr,
    input  logic [7:0] ct_rddata,
    output logic [7:0] pt_addr,
    output logic [7:0] pt_wrdata,
    output logic       pt_wren
);

    typedef enum logic [3:0] {
        IDLE,
        RD_LEN,
        LD_LEN,
        WR_LEN,
        RD_I,
        LD_I,
        RD_J,
        LD_J,
        WR_I,
        WR_J,
        RD_PAD,
        WR_PT
    } state_t;

    state_t     state;
    state_t     state_nx;

    logic [7:0] i_q;
    logic [7:0] j_q;
    logic [7:0] k_q;
    logic [7:0] len_q;
    logic [7:0] si_q;
    logic [7:0] sj_q;
    logic [7:0] ct_q;
    logic       bad_q;

    logic [7:0] pt_byte;
    logic       byte_bad;
    logic       stop;
    logic       start;

    assign pt_byte  = ct_q ^ s_rddata;
    assign byte_bad = CHECK_ASCII &&
                      ((pt_byte < 8'h20) || (pt_byte > 8'h7e));
    assign stop     = (k_q == len_q) || (ABORT_ON_BAD && byte_bad);
    assign start    = (state == IDLE) && en;

    assign rdy      = (state == IDLE);
    assign pt_bad   = bad_q;

    // State register; reset abandons any run in progress.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state sequencing, one cycle per state.
    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    state_nx = start ? RD_LEN : IDLE;
            RD_LEN:  state_nx = LD_LEN;
            LD_LEN:  state_nx = WR_LEN;
            WR_LEN:  state_nx = (len_q == 8'd0) ? IDLE : RD_I;
            RD_I:    state_nx = LD_I;
            LD_I:    state_nx = RD_J;
            RD_J:    state_nx = LD_J;
            LD_J:    state_nx = WR_I;
            WR_I:    state_nx = WR_J;
            WR_J:    state_nx = RD_PAD;
            RD_PAD:  state_nx = WR_PT;
            WR_PT:   state_nx = stop ? IDLE : RD_I;
            default: state_nx = IDLE;
        endcase
    end

    // Datapath registers: indices, length, swap operands, ct byte, flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            i_q   <= 8'd0;
            j_q   <= 8'd0;
            k_q   <= 8'd0;
            len_q <= 8'd0;
            si_q  <= 8'd0;
            sj_q  <= 8'd0;
            ct_q  <= 8'd0;
            bad_q <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (en) begin
                        i_q   <= 8'd0;
                        j_q   <= 8'd0;
                        k_q   <= 8'd0;
                        bad_q <= 1'b0;
                    end
                end
                LD_LEN: len_q <= ct_rddata;
                WR_LEN: k_q   <= 8'd1;
                LD_I: begin
                    si_q <= s_rddata;
                    ct_q <= ct_rddata;
                    i_q  <= i_q + 8'd1;
                    j_q  <= j_q + s_rddata;
                end
                LD_J: sj_q <= s_rddata;
                WR_PT: begin
                    if (byte_bad) begin
                        bad_q <= 1'b1;
                    end
                    if (!stop) begin
                        k_q <= k_q + 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Memory addresses and write strobes decoded from the current state.
    always_comb begin
        s_addr    = 8'd0;
        s_wrdata  = 8'd0;
        s_wren    = 1'b0;
        ct_addr   = 8'd0;
        pt_addr   = 8'd0;
        pt_wrdata = 8'd0;
        pt_wren   = 1'b0;
        unique case (state)
            WR_LEN: begin
                pt_addr   = 8'd0;
                pt_wrdata = len_q;
                pt_wren   = 1'b1;
            end
            RD_I: begin
                s_addr  = i_q + 8'd1;
                ct_addr = k_q;
            end
            RD_J: s_addr = j_q;
            WR_I: begin
                s_addr   = i_q;
                s_wrdata = sj_q;
                s_wren   = 1'b1;
            end
            WR_J: begin
                s_addr   = j_q;
                s_wrdata = si_q;
                s_wren   = 1'b1;
            end
            RD_PAD: s_addr = si_q + sj_q;
            WR_PT: begin
                pt_addr   = k_q;
                pt_wrdata = pt_byte;
                pt_wren   = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_arc4_prga.sv
// Bench for arc4_prga: two instances (abort on / abort off)
// with behavioural S/ct/pt memories and a plain ARC4 reference.
module tb_arc4_prga;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en        [2];
    logic       rdy       [2];
    logic       pt_bad    [2];
    logic [7:0] s_addr    [2];
    logic [7:0] s_rddata  [2];
    logic [7:0] s_wrdata  [2];
    logic       s_wren    [2];
    logic [7:0] ct_addr   [2];
    logic [7:0] ct_rddata [2];
    logic [7:0] pt_addr   [2];
    logic [7:0] pt_wrdata [2];
    logic       pt_wren   [2];

    logic [7:0] smem  [2][256];
    logic [7:0] ctmem [2][256];
    logic [7:0] ptmem [2][256];
    int s_wr_cnt  [2] = '{0, 0};
    int pt_wr_cnt [2] = '{0, 0};
    int both_cnt  [2] = '{0, 0};

    int checks = 0;
    int errors = 0;

    logic [7:0] ms  [256];
    logic [7:0] mpt [256];
    int mpt_n;
    int ms_wr;
    bit mbad;

    always #5 clk = ~clk;

    arc4_prga #(.CHECK_ASCII(1'b1), .ABORT_ON_BAD(1'b1)) dut_abort (
        .clk(clk), .rst_n(rst_n), .en(en[0]), .rdy(rdy[0]),
        .pt_bad(pt_bad[0]), .s_addr(s_addr[0]),
        .s_rddata(s_rddata[0]), .s_wrdata(s_wrdata[0]),
        .s_wren(s_wren[0]), .ct_addr(ct_addr[0]),
        .ct_rddata(ct_rddata[0]), .pt_addr(pt_addr[0]),
        .pt_wrdata(pt_wrdata[0]), .pt_wren(pt_wren[0])
    );

    arc4_prga #(.CHECK_ASCII(1'b1), .ABORT_ON_BAD(1'b0)) dut_full (
        .clk(clk), .rst_n(rst_n), .en(en[1]), .rdy(rdy[1]),
        .pt_bad(pt_bad[1]), .s_addr(s_addr[1]),
        .s_rddata(s_rddata[1]), .s_wrdata(s_wrdata[1]),
        .s_wren(s_wren[1]), .ct_addr(ct_addr[1]),
        .ct_rddata(ct_rddata[1]), .pt_addr(pt_addr[1]),
        .pt_wrdata(pt_wrdata[1]), .pt_wren(pt_wren[1])
    );

    // Synchronous memories with one-cycle read latency.
    always @(posedge clk) begin
        for (int u = 0; u < 2; u++) begin
            s_rddata[u]  <= smem[u][s_addr[u]];
            ct_rddata[u] <= ctmem[u][ct_addr[u]];
            if (s_wren[u]) begin
                smem[u][s_addr[u]] <= s_wrdata[u];
                s_wr_cnt[u] <= s_wr_cnt[u] + 1;
            end
            if (pt_wren[u]) begin
                ptmem[u][pt_addr[u]] <= pt_wrdata[u];
                pt_wr_cnt[u] <= pt_wr_cnt[u] + 1;
            end
            if (s_wren[u] && pt_wren[u]) begin
                both_cnt[u] <= both_cnt[u] + 1;
            end
        end
    end

    task automatic load_identity(input int u);
        for (int x = 0; x < 256; x++) begin
            smem[u][x]  = 8'(x);
            ptmem[u][x] = 8'hEE;
        end
    endtask

    task automatic load_perm(input int u);
        logic [7:0] t;
        int r;
        load_identity(u);
        for (int x = 255; x > 0; x--) begin
            r = $urandom_range(0, x);
            t = smem[u][x];
            smem[u][x] = smem[u][r];
            smem[u][r] = t;
        end
    endtask

    // Plain ARC4 PRGA on a copy of the current S and ct memories.
    task automatic ref_run(input int u, input bit abort);
        logic [7:0] i;
        logic [7:0] j;
        logic [7:0] t;
        logic [7:0] b;
        int len;
        for (int x = 0; x < 256; x++) ms[x] = smem[u][x];
        len = int'(ctmem[u][0]);
        mpt[0] = ctmem[u][0];
        mpt_n = 1;
        ms_wr = 0;
        mbad = 1'b0;
        i = 8'd0;
        j = 8'd0;
        for (int k = 1; k <= len; k++) begin
            i = i + 8'd1;
            j = j + ms[i];
            t = ms[i];
            ms[i] = ms[j];
            ms[j] = t;
            ms_wr += 2;
            t = ms[i] + ms[j];
            b = ctmem[u][k] ^ ms[t];
            mpt[k] = b;
            mpt_n++;
            if (b < 8'h20 || b > 8'h7e) begin
                mbad = 1'b1;
                if (abort) break;
            end
        end
    endtask

    task automatic exec(input int u, input int poke,
                        output int sdel, output int pdel);
        int s0;
        int p0;
        int b0;
        int cyc;
        int len;
        int bad_s;
        int bad_p;
        ref_run(u, u == 0);
        s0 = s_wr_cnt[u];
        p0 = pt_wr_cnt[u];
        b0 = both_cnt[u];
        len = int'(ctmem[u][0]);
        @(negedge clk);
        en[u] = 1'b1;
        @(posedge clk);
        #1;
        en[u] = 1'b0;
        checks++;
        if (rdy[u] !== 1'b0 || pt_bad[u] !== 1'b0) begin
            errors++;
            $display("FAIL accept u=%0d: rdy=%b pt_bad=%b, required 0 0",
                     u, rdy[u], pt_bad[u]);
        end
        cyc = 0;
        while (rdy[u] !== 1'b1 && cyc < 4 + 8 * len + 20) begin
            en[u] = (poke != 0) && (cyc == poke || cyc == poke + 7);
            @(posedge clk);
            #1;
            cyc++;
        end
        en[u] = 1'b0;
        checks++;
        if (rdy[u] !== 1'b1 || cyc > 4 + 8 * len) begin
            errors++;
            $display("FAIL latency u=%0d: %0d cycles rdy=%b, limit %0d",
                     u, cyc, rdy[u], 4 + 8 * len);
        end
        sdel = s_wr_cnt[u] - s0;
        pdel = pt_wr_cnt[u] - p0;
        checks++;
        if (pt_bad[u] !== mbad) begin
            errors++;
            $display("FAIL pt_bad u=%0d: got %b, required %b",
                     u, pt_bad[u], mbad);
        end
        checks++;
        if (sdel != ms_wr) begin
            errors++;
            $display("FAIL s_writes u=%0d: got %0d, required %0d",
                     u, sdel, ms_wr);
        end
        checks++;
        if (pdel != mpt_n) begin
            errors++;
            $display("FAIL pt_writes u=%0d: got %0d, required %0d",
                     u, pdel, mpt_n);
        end
        checks++;
        if (both_cnt[u] != b0) begin
            errors++;
            $display("FAIL both_wren u=%0d: got %0d cycles, required 0",
                     u, both_cnt[u] - b0);
        end
        bad_s = 0;
        for (int x = 0; x < 256; x++) begin
            if (smem[u][x] !== ms[x]) bad_s++;
        end
        checks++;
        if (bad_s != 0) begin
            errors++;
            $display("FAIL s_contents u=%0d: %0d differ, required 0",
                     u, bad_s);
        end
        bad_p = 0;
        for (int k = 0; k < mpt_n; k++) begin
            if (ptmem[u][k] !== mpt[k]) bad_p++;
        end
        checks++;
        if (bad_p != 0) begin
            errors++;
            $display("FAIL pt_contents u=%0d: %0d differ, required 0",
                     u, bad_p);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        en[0] = 1'b0;
        en[1] = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        for (int u = 0; u < 2; u++) begin
            checks++;
            if (rdy[u] !== 1'b1 || pt_bad[u] !== 1'b0) begin
                errors++;
                $display("FAIL reset_flags u=%0d: rdy=%b pt_bad=%b, req 1 0",
                         u, rdy[u], pt_bad[u]);
            end
            checks++;
            if (s_wren[u] !== 1'b0 || pt_wren[u] !== 1'b0 ||
                s_addr[u] !== 8'd0 || ct_addr[u] !== 8'd0 ||
                pt_addr[u] !== 8'd0 || s_wrdata[u] !== 8'd0 ||
                pt_wrdata[u] !== 8'd0) begin
                errors++;
                $display("FAIL reset_outs u=%0d: wren=%b%b addr=%h/%h/%h, req 0",
                         u, s_wren[u], pt_wren[u], s_addr[u],
                         ct_addr[u], pt_addr[u]);
            end
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_one_byte();
        int sd;
        int pd;
        load_identity(0);
        ctmem[0][0] = 8'h01;
        ctmem[0][1] = 8'h41;
        exec(0, 0, sd, pd);
        checks++;
        if (ptmem[0][0] !== 8'h01 || ptmem[0][1] !== 8'h43) begin
            errors++;
            $display("FAIL one_byte: pt=%h %h, required 01 43",
                     ptmem[0][0], ptmem[0][1]);
        end
    endtask

    task automatic test_two_bytes();
        int sd;
        int pd;
        load_identity(0);
        ctmem[0][0] = 8'h02;
        ctmem[0][1] = 8'h41;
        ctmem[0][2] = 8'h41;
        exec(0, 0, sd, pd);
        checks++;
        if (ptmem[0][2] !== 8'h44 || smem[0][2] !== 8'h03 ||
            smem[0][3] !== 8'h02 || sd != 4) begin
            errors++;
            $display("FAIL two_bytes: pt2=%h S2=%h S3=%h sw=%0d, req 44 03 02 4",
                     ptmem[0][2], smem[0][2], smem[0][3], sd);
        end
    endtask

    task automatic test_zero_len();
        int sd;
        int pd;
        load_identity(1);
        ctmem[1][0] = 8'h00;
        exec(1, 0, sd, pd);
        checks++;
        if (ptmem[1][0] !== 8'h00 || sd != 0 || pd != 1) begin
            errors++;
            $display("FAIL zero_len: pt0=%h sw=%0d pw=%0d, required 00 0 1",
                     ptmem[1][0], sd, pd);
        end
    endtask

    task automatic test_abort();
        int sd;
        int pd;
        for (int u = 0; u < 2; u++) begin
            load_identity(u);
            ctmem[u][0] = 8'h05;
            ctmem[u][1] = 8'h02;
            for (int k = 2; k <= 5; k++) ctmem[u][k] = 8'($urandom);
            exec(u, 0, sd, pd);
            checks++;
            if (ptmem[u][1] !== 8'h00 || pt_bad[u] !== 1'b1 ||
                pd != (u == 0 ? 2 : 6)) begin
                errors++;
                $display("FAIL abort u=%0d: pt1=%h bad=%b pw=%0d, req 00 1 %0d",
                         u, ptmem[u][1], pt_bad[u], pd, u == 0 ? 2 : 6);
            end
        end
    endtask

    task automatic test_ignore_en();
        int sd;
        int pd;
        load_identity(0);
        ctmem[0][0] = 8'h02;
        ctmem[0][1] = 8'h41;
        ctmem[0][2] = 8'h41;
        exec(0, 3, sd, pd);
        checks++;
        if (ptmem[0][2] !== 8'h44 || sd != 4 || pd != 3) begin
            errors++;
            $display("FAIL ignore_en: pt2=%h sw=%0d pw=%0d, required 44 4 3",
                     ptmem[0][2], sd, pd);
        end
    endtask

    task automatic test_reset_mid();
        int cyc;
        int s0;
        int p0;
        int sd;
        int pd;
        load_identity(0);
        ctmem[0][0] = 8'h02;
        ctmem[0][1] = 8'h41;
        ctmem[0][2] = 8'h41;
        @(negedge clk);
        en[0] = 1'b1;
        @(posedge clk);
        #1;
        en[0] = 1'b0;
        cyc = 0;
        while (s_wren[0] !== 1'b1 && cyc < 20) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        checks++;
        if (s_wren[0] !== 1'b1) begin
            errors++;
            $display("FAIL reach_wr_i: s_wren=%b after %0d cycles, req 1",
                     s_wren[0], cyc);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (rdy[0] !== 1'b1 || s_wren[0] !== 1'b0 || pt_wren[0] !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: rdy=%b s_wren=%b pt_wren=%b, req 1 0 0",
                     rdy[0], s_wren[0], pt_wren[0]);
        end
        s0 = s_wr_cnt[0];
        p0 = pt_wr_cnt[0];
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (s_wr_cnt[0] != s0 || pt_wr_cnt[0] != p0) begin
            errors++;
            $display("FAIL writes_in_reset: %0d s and %0d pt writes, req 0",
                     s_wr_cnt[0] - s0, pt_wr_cnt[0] - p0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        load_identity(0);
        exec(0, 0, sd, pd);
    endtask

    task automatic test_random();
        int sd;
        int pd;
        int u;
        int len;
        logic [7:0] pad [256];
        for (int it = 0; it < 12; it++) begin
            u = it % 2;
            load_perm(u);
            len = $urandom_range(1, 30);
            ctmem[u][0] = 8'(len);
            if (it % 4 < 2) begin
                for (int k = 1; k <= len; k++) ctmem[u][k] = 8'($urandom);
            end else begin
                for (int k = 1; k <= len; k++) ctmem[u][k] = 8'h00;
                ref_run(u, 1'b0);
                for (int k = 1; k <= len; k++) pad[k] = mpt[k];
                for (int k = 1; k <= len; k++) begin
                    ctmem[u][k] = pad[k] ^ 8'($urandom_range(32, 126));
                end
                if (it % 8 == 2) begin
                    ctmem[u][$urandom_range(1, len)] ^= 8'h80;
                end
            end
            exec(u, 0, sd, pd);
        end
    endtask

    initial begin
        test_reset();
        test_one_byte();
        test_two_bytes();
        test_zero_len();
        test_abort();
        test_ignore_en();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/arc4_prga.md
Name: arc4_prga

Overview:
- Pseudo-random generation and decryption stage of the ARC4 datapath.
- Runs after key scheduling has permuted S memory.
- Reads a length-prefixed ciphertext message, generates the keystream from S, and writes the length-prefixed plaintext.
- Sits directly upstream of the cracker's plaintext checker and flags any non-printable byte, so the cracker can abandon a candidate key early.

Parameters:
- CHECK_ASCII, 1: 1 = evaluate each plaintext byte against 0x20..0x7E and drive pt_bad; 0 = pt_bad held 0.
- ABORT_ON_BAD, 1: 1 = stop right after writing the first bad byte; 0 = always process all L bytes. Has no effect when CHECK_ASCII=0.

Ports:
- clk  in  1  system clock; all memories are synchronous on clk.
- rst_n  in  1  asynchronous active-low reset.
- en  in  1  start request; sampled only while rdy=1.
- rdy  out  1  high when idle and able to accept en.
- pt_bad  out  1  sticky; high if any written byte k>=1 lies outside 0x20..0x7E; cleared on accepted en.
- s_addr  out  8  S memory address.
- s_rddata  in  8  S read data; valid 1 cycle after s_addr is sampled.
- s_wrdata  out  8  S write data.
- s_wren  out  1  S write enable.
- ct_addr  out  8  ciphertext memory address.
- ct_rddata  in  8  ciphertext read data; 1-cycle read latency.
- pt_addr  out  8  plaintext memory address.
- pt_wrdata  out  8  plaintext write data.
- pt_wren  out  1  plaintext write enable.

Behaviour:
Reset values (asynchronous on rst_n=0):
- State IDLE; rdy=1; pt_bad=0.
- All addresses, write data and write enables = 0.
- Internal i, j, k, L, si, sj = 0.

Handshake:
- en is accepted on a cycle with rdy=1 and en=1. rdy drops the next cycle.
- en asserted while rdy=0 is ignored.
- rdy returns high for one or more cycles after the final write. It may be re-accepted on the first cycle rdy is back high.

Algorithm (all arithmetic 8-bit, mod 256):
- i=0, j=0.
- For k=1..L:
  - i=i+1; j=j+S[i]
  - swap S[i], S[j]
  - pad=S[S[i]+S[j]]
  - pt[k]=ct[k] xor pad
- pt[0]=L.

State machine, one cycle per state:
- IDLE
- RD_LEN: ct_addr=0.
- LD_LEN: capture L.
- WR_LEN: pt[0]=L. Go to IDLE if L==0, else to RD_I.
- RD_I: s_addr=i+1, ct_addr=k.
- LD_I: si=s_rddata, i=i+1, j=j+si.
- RD_J: s_addr=j.
- LD_J: capture sj.
- WR_I: S[i]=sj.
- WR_J: S[j]=si.
- RD_PAD: s_addr=si+sj.
- WR_PT: pt[k]=ct_byte xor s_rddata; evaluate ASCII.
- Then: if k==L or (ABORT_ON_BAD and byte bad), go to IDLE; else k=k+1 and go to RD_I.

Per-byte cost is 8 cycles. rdy is high no later than 4+8*L cycles after the accepting edge.

Rules:
- ct[k] is captured in LD_I and held in a register through WR_PT.
- Only one of s_wren/pt_wren is high in any cycle.
- Write enables are high only in WR_LEN, WR_I, WR_J and WR_PT.
- i==j: both swap writes target the same address with the same value. S is unchanged; no special-casing.
- j wraps freely. i never exceeds 255, since L<=255.
- si+sj overflow is truncated to 8 bits.
- Reset mid-operation: return to IDLE immediately; no further writes. S and pt contents are left as-is; the caller must re-run key scheduling.
- pt_bad is registered in WR_PT and held until the next accepted en.

Test Plan:
1. S identity (S[x]=x), ct={0x01,0x41}, pulse en -> pt[0]=0x01, pt[1]=0x43, S unchanged (i=j=1), pt_bad=0, rdy high within 12 cycles.
2. S identity, ct={0x02,0x41,0x41} -> pt[2]=0x44, S[2]=0x03, S[3]=0x02, all other S[x]=x, exactly 4 S writes total.
3. ct={0x00} -> pt[0]=0x00, zero S writes, exactly one pt write, rdy back within 4 cycles.
4. S identity, ct={0x05,0x02,...}, ABORT_ON_BAD=1 -> pt[1]=0x00, pt_bad=1, no pt writes at addresses 2..5; repeat with ABORT_ON_BAD=0 -> all 5 bytes written, pt_bad stays 1.
5. en pulsed again mid-run -> ignored, results identical to scenario 2; a subsequent en after rdy returns clears pt_bad.
6. rst_n low during WR_I of byte 1 -> rdy=1 and all wren=0 asynchronously, no further memory writes; a fresh en then completes normally.
